// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/issue/resolve sequencer for the 9-bit CPU.
// Optional single-step support is enabled with `define SEQ_STEP_EN.
module cpu_sequencer #(
   parameter int PC_W       = 10,
   parameter int EX_TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic            ins_req,
   input  logic            ins_ack,
   input  logic [8:0]      ins_data,
   output logic [PC_W-1:0] pc,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic            ex_alu,
   output logic [4:0]      ex_rop,
   output logic [3:0]      ex_mth,
   output logic [3:0]      ex_reg,
   input  logic            cond_zero,
   input  logic [8:0]      tgt,
   output logic            done,
   output logic            err
`ifdef SEQ_STEP_EN
   ,
   input  logic            step_mode,
   input  logic            step,
   output logic            paused
`endif
);

   localparam logic [4:0] OP_JIZR = 5'd12;
   localparam logic [4:0] OP_JNZR = 5'd13;
   localparam logic [4:0] OP_BIZR = 5'd14;
   localparam logic [4:0] OP_BNZR = 5'd15;
   localparam logic [4:0] OP_FUNC = 5'd23;
   localparam logic [4:0] OP_LJP0 = 5'd24;
   localparam logic [4:0] OP_LJP1 = 5'd25;
   localparam logic [4:0] OP_LJP2 = 5'd26;
   localparam logic [4:0] OP_LJP3 = 5'd27;
   localparam logic [7:0] TMO     = 8'(EX_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_RESOLVE, S_HALT, S_ERR, S_PAUSE
   } state_t;

   state_t          state, nxt;
   logic [8:0]      ins;
   logic [7:0]      cnt;
   logic            cz_q;
   logic [8:0]      tgt_q;
   logic [PC_W-1:0] pc_nxt;
   logic [4:0]      op;
   logic            is_alu, illegal, is_halt;

   assign op      = ins[8:4];
   assign is_alu  = (op < 5'd4);
   assign is_halt = (op == OP_FUNC) && (ins[1:0] == 2'b11);

   always_comb begin
      case (op)
         5'd7, 5'd8, 5'd9, 5'd16, 5'd18, 5'd19,
         5'd28, 5'd29, 5'd30, 5'd31: illegal = 1'b1;
         default:                    illegal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt      = state;
      ins_req  = 1'b0;
      ex_valid = 1'b0;
      done     = 1'b0;
      err      = 1'b0;
`ifdef SEQ_STEP_EN
      paused   = 1'b0;
`endif
      case (state)
         S_IDLE:   if (start) nxt = S_FETCH;
         S_FETCH: begin
            ins_req = 1'b1;
            if (ins_ack) nxt = S_DECODE;
         end
         S_DECODE: begin
            if (illegal)      nxt = S_ERR;
            else if (is_halt) nxt = S_HALT;
            else              nxt = S_ISSUE;
         end
         S_ISSUE: begin
            ex_valid = 1'b1;
            // completion takes priority over a timeout in the same cycle
            if (ex_ready)         nxt = S_RESOLVE;
            else if (cnt == TMO)  nxt = S_ERR;
         end
         S_RESOLVE: begin
`ifdef SEQ_STEP_EN
            nxt = step_mode ? S_PAUSE : S_FETCH;
`else
            nxt = S_FETCH;
`endif
         end
         S_HALT: begin
            done = 1'b1;
            if (start) nxt = S_FETCH;
         end
         S_ERR: begin
            err = 1'b1;
            if (start) nxt = S_FETCH;
         end
`ifdef SEQ_STEP_EN
         S_PAUSE: begin
            paused = 1'b1;
            if (step || !step_mode) nxt = S_FETCH;
         end
`endif
         default:  nxt = S_IDLE;
      endcase
   end

   // Branch offsets are relative to the branch's own address, which pc still holds here.
   always_comb begin
      pc_nxt = pc + PC_W'(1);
      case (ex_rop)
         OP_JIZR: if (cz_q)  pc_nxt = PC_W'(tgt_q);
         OP_JNZR: if (!cz_q) pc_nxt = PC_W'(tgt_q);
         OP_BIZR: if (cz_q)  pc_nxt = pc + PC_W'($signed(tgt_q));
         OP_BNZR: if (!cz_q) pc_nxt = pc + PC_W'($signed(tgt_q));
         OP_LJP0, OP_LJP1, OP_LJP2, OP_LJP3:
                  pc_nxt = PC_W'({ex_rop[1:0], tgt_q[7:0]});
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc     <= '0;
         ins    <= '0;
         ex_alu <= 1'b0;
         ex_rop <= '0;
         ex_mth <= '0;
         ex_reg <= '0;
         cnt    <= '0;
         cz_q   <= 1'b0;
         tgt_q  <= '0;
      end else begin
         case (state)
            S_IDLE, S_HALT, S_ERR: if (start) pc <= '0;
            S_FETCH:  if (ins_ack) ins <= ins_data;
            S_DECODE: begin
               ex_alu <= is_alu;
               ex_rop <= op;
               ex_mth <= is_alu ? ins[5:2] : 4'h0;
               ex_reg <= is_alu ? {2'b00, ins[1:0]} : ins[3:0];
               cnt    <= 8'd1;
            end
            S_ISSUE: begin
               if (ex_ready) begin
                  cz_q  <= cond_zero;
                  tgt_q <= tgt;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_RESOLVE: pc <= pc_nxt;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with an instruction-level reference model.
module tb_cpu_sequencer;
   localparam int PC_W = 10;
   localparam int EX_TIMEOUT = 255;

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic ins_req, ins_ack, ex_valid, ex_ready, ex_alu, cond_zero, done, err;
   logic [8:0] ins_data, tgt;
   logic [PC_W-1:0] pc;
   logic [4:0] ex_rop;
   logic [3:0] ex_mth, ex_reg;
`ifdef SEQ_STEP_EN
   logic step_mode = 1'b0, step = 1'b0, paused;
`endif

   cpu_sequencer #(.PC_W(PC_W), .EX_TIMEOUT(EX_TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .ins_req(ins_req), .ins_ack(ins_ack), .ins_data(ins_data), .pc(pc),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu(ex_alu), .ex_rop(ex_rop),
      .ex_mth(ex_mth), .ex_reg(ex_reg), .cond_zero(cond_zero), .tgt(tgt),
      .done(done), .err(err)
`ifdef SEQ_STEP_EN
      , .step_mode(step_mode), .step(step), .paused(paused)
`endif
   );

   always #5 clk = ~clk;

   // program memory and datapath stimulus, indexed by the address being fetched/issued
   logic [8:0] mem     [0:1023];
   logic [8:0] tgt_tab [0:1023];
   logic       cz_tab  [0:1023];
   int ack_wait = 0, rdy_delay = 1, fcnt = 0, vcnt = 0;

   assign ins_ack   = ins_req && (fcnt >= ack_wait);
   assign ins_data  = mem[pc];
   assign ex_ready  = ex_valid && (vcnt == rdy_delay);
   assign cond_zero = cz_tab[pc];
   assign tgt       = tgt_tab[pc];

   always @(posedge clk) begin
      fcnt <= (ins_req && !ins_ack) ? fcnt + 1 : 0;
      vcnt <= (ex_valid && !ex_ready) ? vcnt + 1 : 0;
   end

   int checks = 0, failures = 0, n_issue = 0, cyc = 0, exp_pc = 0;
   logic [8:0] m_word = '0;
   bit m_issue = 0, m_idle = 1;
   int ack_t[$];

   task automatic chk(input string nm, input int act, input int expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, expv);
      end
   endtask

   task automatic tmo(input string nm);
      checks++;
      failures++;
      $display("FAIL %s: timed out waiting, got 0 expected 1", nm);
   endtask

   function automatic bit legal(input int op);
      return !(op inside {7, 8, 9, 16, 18, 19, [28:31]});
   endfunction

   // Instruction-level next-PC rule
   function automatic int nxt_pc(input int p, input logic [8:0] w, input logic cz, input logic [8:0] t);
      int op = int'(w[8:4]);
      int m = 1 << PC_W;
      int off;
      if ((op == 12 && cz) || (op == 13 && !cz)) return int'(t) % m;
      if ((op == 14 && cz) || (op == 15 && !cz)) begin
         off = (t >= 9'd256) ? int'(t) - 512 : int'(t);
         return ((p + off) % m + m) % m;
      end
      if (op >= 24 && op <= 27) return ((op - 24) * 256 + int'(t[7:0])) % m;
      return (p + 1) % m;
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         exp_pc = 0; m_idle = 1; m_issue = 0;
      end else begin
         if (ins_req) chk("fetch_pc", int'(pc), exp_pc);
         if (done || err) chk("hold_pc", int'(pc), exp_pc);
         if (ins_req && ins_ack) begin
            m_word  = ins_data;
            m_issue = legal(int'(m_word[8:4])) && !(m_word[8:4] == 5'd23 && m_word[1:0] == 2'b11);
            ack_t.push_back(cyc);
         end
         if (ex_valid) begin
            chk("issue_allowed", int'(m_issue), 1);
            chk("ex_alu", int'(ex_alu), int'(m_word[8:4] < 5'd4));
            if (m_word[8:4] < 5'd4) begin
               chk("ex_mth", int'(ex_mth), int'(m_word[5:2]));
               chk("ex_reg_alu", int'(ex_reg), int'(m_word[1:0]));
            end else begin
               chk("ex_rop", int'(ex_rop), int'(m_word[8:4]));
               chk("ex_reg", int'(ex_reg), int'(m_word[3:0]));
            end
            if (ex_ready) begin
               n_issue++;
               exp_pc = nxt_pc(exp_pc, m_word, cond_zero, tgt);
            end
         end
         if (start && (m_idle || done || err)) begin exp_pc = 0; m_idle = 0; end
      end
   end

   task automatic rst();
      rst_n = 1'b0; start = 1'b0; ack_wait = 0; rdy_delay = 1;
      for (int i = 0; i < 1024; i++) begin mem[i] = 9'h173; tgt_tab[i] = '0; cz_tab[i] = 1'b0; end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_end(input string nm);
      int k = 0;
      while (!(done || err) && k < 2000) begin @(negedge clk); k++; end
      if (!(done || err)) tmo(nm);
   endtask

   int base, nv, k, b0;

   initial begin
      for (int i = 0; i < 1024; i++) begin mem[i] = 9'h173; tgt_tab[i] = '0; cz_tab[i] = 1'b0; end
      #3;
      chk("rst_pc", int'(pc), 0);
      chk("rst_req", int'(ins_req), 0);
      chk("rst_valid", int'(ex_valid), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_fields", int'({ex_alu, ex_rop, ex_mth, ex_reg}), 0);
      rst();
      repeat (3) @(negedge clk);
      chk("idle_req", int'(ins_req), 0);

      // three increments then done
      rst();
      for (int i = 0; i < 3; i++) mem[i] = 9'h0A0;
      base = n_issue;
      pulse_start(); wait_end("t1_end");
      chk("t1_issues", n_issue - base, 3);
      chk("t1_pc", int'(pc), 3);
      chk("t1_done", int'(done), 1);
      chk("t1_err", int'(err), 0);

      // zero-wait latency
      rst();
      mem[0] = 9'h0A0; mem[1] = 9'h0A0; rdy_delay = 0;
      b0 = ack_t.size();
      pulse_start(); wait_end("lat_end");
      chk("lat_0_1", ack_t[b0+1] - ack_t[b0], 4);
      chk("lat_1_2", ack_t[b0+2] - ack_t[b0+1], 4);
      chk("lat_pc", int'(pc), 2);

      // ALU word with fetch wait states
      rst();
      mem[0] = 9'h023; ack_wait = 2;
      pulse_start();
      k = 0;
      while (!ex_valid && k < 100) begin @(negedge clk); k++; end
      if (!ex_valid) tmo("alu_valid");
      chk("alu_cls", int'(ex_alu), 1);
      chk("alu_mth", int'(ex_mth), 8);
      chk("alu_reg", int'(ex_reg), 3);
      wait_end("alu_end");
      chk("alu_pc", int'(pc), 1);

      // bnzrEn at pc 5, taken and not taken
      for (int c = 0; c < 2; c++) begin
         rst();
         mem[0] = 9'h180; tgt_tab[0] = 9'h005;
         mem[5] = 9'h0F1; tgt_tab[5] = 9'h1FE; cz_tab[5] = c[0];
         base = n_issue;
         pulse_start(); wait_end("br_end");
         chk(c == 0 ? "bnzr_taken_pc" : "bnzr_not_pc", int'(pc), c == 0 ? 3 : 6);
         chk("br_issues", n_issue - base, 2);
      end

      // ljp2
      rst();
      mem[0] = 9'h1A0; tgt_tab[0] = 9'h045;
      pulse_start(); wait_end("ljp_end");
      chk("ljp2_pc", int'(pc), 'h245);

      // ljp3 to 0x3FF, then untaken jizrEn wraps to 0
      rst();
      mem[0] = 9'h1B0; tgt_tab[0] = 9'h0FF;
      mem[10'h3FF] = 9'h0C0; tgt_tab[10'h3FF] = 9'h055;
      base = n_issue;
      pulse_start();
      k = 0;
      while (n_issue == base && k < 100) begin @(negedge clk); k++; end
      mem[0] = 9'h173;
      wait_end("wrap_end");
      chk("wrap_pc", int'(pc), 0);
      chk("wrap_issues", n_issue - base, 2);
      chk("wrap_done", int'(done), 1);

      // illegal opcode, then restart
      rst();
      mem[0] = 9'h0A0; mem[1] = 9'h070;
      pulse_start();
      k = 0;
      while (!(ins_req && ins_ack && pc == 1) && k < 100) begin @(negedge clk); k++; end
      if (k >= 100) tmo("ill_fetch");
      @(negedge clk); chk("ill_decode_err", int'(err), 0);
      @(negedge clk); chk("ill_err", int'(err), 1); chk("ill_pc", int'(pc), 1);
      repeat (3) @(negedge clk);
      chk("ill_hold_err", int'(err), 1);
      chk("ill_hold_valid", int'(ex_valid), 0);
      mem[1] = 9'h173;
      pulse_start();
      @(negedge clk);
      chk("restart_err", int'(err), 0);
      chk("restart_req", int'(ins_req), 1);
      chk("restart_pc", int'(pc), 0);
      wait_end("restart_end");
      chk("restart_done", int'(done), 1);

      // ex_ready withheld: timeout
      rst();
      mem[0] = 9'h0A0; rdy_delay = 1000;
      pulse_start();
      nv = 0; k = 0;
      while (!err && k < 400) begin @(negedge clk); if (ex_valid) nv++; k++; end
      chk("tmo_cycles", nv, 255);
      chk("tmo_err", int'(err), 1);
      chk("tmo_pc", int'(pc), 0);
      chk("tmo_valid", int'(ex_valid), 0);

      // ex_ready on the last allowed cycle completes
      rst();
      mem[0] = 9'h0A0; rdy_delay = 254;
      base = n_issue;
      pulse_start(); wait_end("edge_end");
      chk("edge_done", int'(done), 1);
      chk("edge_err", int'(err), 0);
      chk("edge_pc", int'(pc), 1);
      chk("edge_issues", n_issue - base, 1);

      // asynchronous reset while issuing
      rst();
      mem[0] = 9'h0A0; mem[1] = 9'h0A0; rdy_delay = 5;
      pulse_start();
      k = 0;
      while (!(ex_valid && pc == 1) && k < 100) begin @(negedge clk); k++; end
      if (k >= 100) tmo("arst_valid");
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", int'(ex_valid), 0);
      chk("arst_req", int'(ins_req), 0);
      chk("arst_pc", int'(pc), 0);
      chk("arst_done", int'(done), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

`ifdef SEQ_STEP_EN
      rst();
      mem[0] = 9'h0A0; mem[1] = 9'h0A0; step_mode = 1'b1;
      base = n_issue;
      pulse_start();
      for (int i = 0; i < 2; i++) begin
         k = 0;
         while (!paused && k < 100) begin @(negedge clk); k++; end
         if (!paused) tmo("step_pause");
         chk("step_issues", n_issue - base, i + 1);
         chk("step_pc", int'(pc), i + 1);
         repeat (3) @(negedge clk);
         chk("step_held", int'(paused), 1);
         chk("step_held_issues", n_issue - base, i + 1);
         @(posedge clk); #1 step = 1'b1;
         @(posedge clk); #1 step = 1'b0;
      end
      wait_end("step_end");
      chk("step_done", int'(done), 1);
      step_mode = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
